multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle control unit.
- Registered FSM sequences each RV32I instruction over 3-5 cycles: fetch, decode, execute, memory, writeback.
- Drives the shared-memory multicycle datapath.
- Adds over the single-cycle unit:
  - memory wait-state handshake;
  - full branch set (beq/bne/blt/bge/bltu/bgeu), jalr and lui;
  - sticky illegal-instruction trap;
  - retire pulse.

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/mc_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes
// and the select codes it drives onto the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_TRAP
  } state_e;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // funct3 001/101 encode shift operations, which decode to TRAP.
  function automatic logic is_shift(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface multicycle_controller_if #(
  parameter int IMM_SRC_W = 3,
  parameter int ALUCTRL_W = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 LT;
  logic                 LTU;
  logic                 mem_ready;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 RegWrite;
  logic [IMM_SRC_W-1:0] ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 instr_done;
  logic                 illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, LT, LTU, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, LT, LTU, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, instr_done, illegal
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALUControl decode from the FSM's ALU-op class and the instruction funct fields.
module mc_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM driving a shared-memory datapath.
// FETCH, DECODE        instruction fetch / target precompute into ALUOut
// MEMADR..MEMWRITE     load/store address, access, load writeback
// EXECR/EXECI, ALUWB   ALU ops; BRANCH; JAL; JALR/JALR2; LUI; TRAP (sticky)
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit WAIT_EN   = 1'b1,
  parameter int IMM_SRC_W = 3,
  parameter int ALUCTRL_W = 3
) (
  input logic              clk,
  input logic              reset_n,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       ready, taken, br_ok;
  alu_op_e    alu_op;
  logic [2:0] alu_ctrl, imm_src;
  logic       pc_write, mem_write, ir_write, reg_write, done, adr_src;
  logic [1:0] result_src, src_a, src_b;

  assign ready = WAIT_EN ? bus.mem_ready : 1'b1;

  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.LT;
      3'b101:  taken = !bus.LT;
      3'b110:  taken = bus.LTU;
      3'b111:  taken = !bus.LTU;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (bus.op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    alu_op     = ALUOP_FUNCT;
    case (state_q)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        alu_op     = ALUOP_ADD;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a  = SRCA_OLDPC;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_ADD;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  state_d = is_shift(bus.funct3) ? S_TRAP : S_EXECR;
          OP_ITYPE:  state_d = is_shift(bus.funct3) ? S_TRAP : S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        src_a   = SRCA_RD1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a  = SRCA_RD1;
        alu_op = ALUOP_SUB;
        if (br_ok) begin
          pc_write = taken;
          done     = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_TRAP;
        end
      end
      S_JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        alu_op   = ALUOP_ADD;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        result_src = RES_ALURESULT;
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mc_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .op5      (bus.op[5]),
    .alu_ctrl (alu_ctrl)
  );

  // FETCH strobes are mem_ready-gated, so reset must mask them directly.
  assign bus.PCWrite    = pc_write & reset_n;
  assign bus.MemWrite   = mem_write & reset_n;
  assign bus.IRWrite    = ir_write & reset_n;
  assign bus.RegWrite   = reg_write & reset_n;
  assign bus.instr_done = done & reset_n;
  assign bus.illegal    = illegal_q;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = IMM_SRC_W'(imm_src);
  assign bus.ALUControl = ALUCTRL_W'(alu_ctrl);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one WAIT_EN=1 and one WAIT_EN=0 instance.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.IMM_SRC_W(3), .ALUCTRL_W(3)) bus ();
  multicycle_controller_if #(.IMM_SRC_W(3), .ALUCTRL_W(3)) bus_nw ();

  multicycle_controller #(.WAIT_EN(1'b1), .IMM_SRC_W(3), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));
  multicycle_controller #(.WAIT_EN(1'b0), .IMM_SRC_W(3), .ALUCTRL_W(3)) dut_nw (
    .clk(clk), .reset_n(reset_n), .bus(bus_nw.master));

  assign bus_nw.op        = bus.op;
  assign bus_nw.funct3    = bus.funct3;
  assign bus_nw.funct7b5  = bus.funct7b5;
  assign bus_nw.Zero      = bus.Zero;
  assign bus_nw.LT        = bus.LT;
  assign bus_nw.LTU       = bus.LTU;
  assign bus_nw.mem_ready = bus.mem_ready;

  // {PCWrite, MemWrite, IRWrite, RegWrite, instr_done, illegal}
  logic [5:0] sb_m, sb_w;
  assign sb_m = {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.instr_done, bus.illegal};
  assign sb_w = {bus_nw.PCWrite, bus_nw.MemWrite, bus_nw.IRWrite, bus_nw.RegWrite,
                 bus_nw.instr_done, bus_nw.illegal};

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_FET  = 6'b101000;
  localparam logic [5:0] E_WB   = 6'b000110;
  localparam logic [5:0] E_MW   = 6'b010000;
  localparam logic [5:0] E_MWD  = 6'b010010;
  localparam logic [5:0] E_BRT  = 6'b100010;
  localparam logic [5:0] E_BRN  = 6'b000010;
  localparam logic [5:0] E_PC   = 6'b100000;
  localparam logic [5:0] E_JR2  = 6'b100110;
  localparam logic [5:0] E_ILL  = 6'b000001;

  // lw with 2 FETCH stalls and 3 MEMREAD stalls
  localparam bit         RDY_LW [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
  localparam logic [5:0] EXP_LW [10] = '{E_NONE, E_NONE, E_FET, E_NONE, E_NONE,
                                         E_NONE, E_NONE, E_NONE, E_NONE, E_WB};
  // {funct3, Zero, LT, LTU, taken}
  localparam logic [6:0] BR_TAB [10] = '{
    7'b000_100_1, 7'b001_100_0, 7'b001_000_1, 7'b100_010_1, 7'b110_010_0,
    7'b101_010_0, 7'b101_001_1, 7'b111_001_0, 7'b111_010_1, 7'b000_011_0};
  // {is_itype, funct3, funct7b5, expected ALUControl}
  localparam logic [7:0] ALU_TAB [9] = '{
    8'b0_000_1_001, 8'b0_000_0_000, 8'b0_010_0_101, 8'b0_011_0_110, 8'b0_100_0_100,
    8'b0_110_0_011, 8'b0_111_0_010, 8'b1_000_1_000, 8'b1_010_0_101};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rdy, input logic [5:0] exp, input string tag);
    bus.mem_ready = rdy;
    #1;
    chk(tag, 8'(sb_m), 8'(exp));
  endtask

  task automatic cyc_w(input logic rdy, input logic [5:0] exp, input string tag);
    bus.mem_ready = rdy;
    #1;
    chk(tag, 8'(sb_w), 8'(exp));
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Zero      = 1'b0;
    bus.LT        = 1'b0;
    bus.LTU       = 1'b0;
    set_ins(7'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset abandoning a stalled store
    do_reset();
    set_ins(OP_STORE, 3'b010, 1'b0);
    cyc(1, E_FET, "sw_fetch"); tick();
    cyc(0, E_NONE, "sw_decode"); chk("sw_immsrc", 8'(bus.ImmSrc), 8'(IMM_S)); tick();
    cyc(0, E_NONE, "sw_memadr"); tick();
    cyc(0, E_MW, "sw_memwrite_wait"); chk("sw_adrsrc", 8'(bus.AdrSrc), 8'd1); tick();
    cyc(0, E_MW, "sw_memwrite_hold");
    reset_n = 1'b0;
    #1 chk("rst_async_drop", 8'(sb_m), 8'(E_NONE));
    bus.mem_ready = 1'b1;
    #1 chk("rst_strobes_masked", 8'(sb_m), 8'(E_NONE));
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, E_NONE, "rst_release");
    chk("rst_srcb", 8'(bus.ALUSrcB), 8'(SRCB_FOUR));
    chk("rst_resultsrc", 8'(bus.ResultSrc), 8'(RES_ALURESULT));
    cyc(1, E_FET, "rst_fetch_go");

    // lw with wait states
    do_reset();
    set_ins(OP_LOAD, 3'b010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(RDY_LW[i], EXP_LW[i], $sformatf("lw_c%0d", i + 1));
      if (i == 6) chk("lw_adrsrc", 8'(bus.AdrSrc), 8'd1);
      if (i == 9) chk("lw_resultsrc", 8'(bus.ResultSrc), 8'(RES_DATA));
      tick();
    end

    // branch conditions
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_ins(OP_BRANCH, BR_TAB[i][6:4], 1'b0);
      bus.Zero = BR_TAB[i][3];
      bus.LT   = BR_TAB[i][2];
      bus.LTU  = BR_TAB[i][1];
      cyc(1, E_FET, $sformatf("br%0d_fetch", i)); tick();
      cyc(1, E_NONE, $sformatf("br%0d_decode", i));
      chk($sformatf("br%0d_immsrc", i), 8'(bus.ImmSrc), 8'(IMM_B)); tick();
      cyc(1, BR_TAB[i][0] ? E_BRT : E_BRN, $sformatf("br%0d_branch", i));
      chk($sformatf("br%0d_aluctl", i), 8'(bus.ALUControl), 8'(ALU_SUB)); tick();
    end
    set_ins(OP_BRANCH, 3'b010, 1'b0);
    cyc(1, E_FET, "br_bad_fetch"); tick();
    cyc(1, E_NONE, "br_bad_decode"); tick();
    cyc(1, E_NONE, "br_bad_branch"); tick();
    cyc(1, E_ILL, "br_bad_trap");

    // ALU decode through R/I-type execution
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_ins(ALU_TAB[i][7] ? OP_ITYPE : OP_RTYPE, ALU_TAB[i][6:4], ALU_TAB[i][3]);
      cyc(1, E_FET, $sformatf("alu%0d_fetch", i)); tick();
      cyc(1, E_NONE, $sformatf("alu%0d_decode", i)); tick();
      cyc(1, E_NONE, $sformatf("alu%0d_exec", i));
      chk($sformatf("alu%0d_ctl", i), 8'(bus.ALUControl), 8'(ALU_TAB[i][2:0]));
      chk($sformatf("alu%0d_srcb", i), 8'(bus.ALUSrcB), ALU_TAB[i][7] ? 8'(SRCB_IMM) : 8'(SRCB_RD2));
      tick();
      cyc(1, E_WB, $sformatf("alu%0d_wb", i));
      chk($sformatf("alu%0d_wb_ctl", i), 8'(bus.ALUControl), 8'(ALU_TAB[i][2:0])); tick();
    end
    set_ins(OP_RTYPE, 3'b001, 1'b0);
    cyc(1, E_FET, "sll_fetch"); tick();
    cyc(1, E_NONE, "sll_decode"); tick();
    cyc(1, E_ILL, "sll_trap");

    // jal, jalr, lui
    do_reset();
    set_ins(OP_JAL, 3'b000, 1'b0);
    cyc(1, E_FET, "jal_fetch"); tick();
    cyc(1, E_NONE, "jal_decode"); chk("jal_immsrc", 8'(bus.ImmSrc), 8'(IMM_J)); tick();
    cyc(1, E_PC, "jal_jal"); chk("jal_srca", 8'(bus.ALUSrcA), 8'(SRCA_OLDPC)); tick();
    cyc(1, E_WB, "jal_wb"); chk("jal_resultsrc", 8'(bus.ResultSrc), 8'(RES_ALUOUT)); tick();
    set_ins(OP_JALR, 3'b000, 1'b0);
    cyc(1, E_FET, "jalr_fetch"); tick();
    cyc(1, E_NONE, "jalr_decode"); tick();
    cyc(1, E_NONE, "jalr_c1"); chk("jalr_srca", 8'(bus.ALUSrcA), 8'(SRCA_RD1)); tick();
    cyc(1, E_JR2, "jalr_c2"); chk("jalr_resultsrc", 8'(bus.ResultSrc), 8'(RES_ALURESULT)); tick();
    set_ins(OP_LUI, 3'b000, 1'b0);
    cyc(1, E_FET, "lui_fetch"); tick();
    cyc(1, E_NONE, "lui_decode"); tick();
    cyc(1, E_WB, "lui_lui");
    chk("lui_resultsrc", 8'(bus.ResultSrc), 8'(RES_IMMEXT));
    chk("lui_immsrc", 8'(bus.ImmSrc), 8'(IMM_U)); tick();
    cyc(1, E_FET, "lui_next_fetch");

    // WAIT_EN=0 instance ignores mem_ready=0
    do_reset();
    set_ins(OP_JAL, 3'b000, 1'b0);
    cyc_w(0, E_FET, "nw_jal_fetch"); chk("nw_main_stalled", 8'(sb_m), 8'(E_NONE)); tick();
    cyc_w(0, E_NONE, "nw_jal_decode"); tick();
    cyc_w(0, E_PC, "nw_jal_jal"); tick();
    cyc_w(0, E_WB, "nw_jal_wb"); tick();
    cyc_w(0, E_FET, "nw_jal_next_fetch");
    do_reset();
    set_ins(OP_STORE, 3'b010, 1'b0);
    cyc_w(0, E_FET, "nw_sw_fetch"); tick();
    cyc_w(0, E_NONE, "nw_sw_decode"); tick();
    cyc_w(0, E_NONE, "nw_sw_memadr"); tick();
    cyc_w(0, E_MWD, "nw_sw_memwrite"); tick();
    cyc_w(0, E_FET, "nw_sw_next_fetch");
    do_reset();
    set_ins(OP_LOAD, 3'b010, 1'b0);
    cyc_w(0, E_FET, "nw_lw_fetch"); tick();
    cyc_w(0, E_NONE, "nw_lw_decode"); tick();
    cyc_w(0, E_NONE, "nw_lw_memadr"); tick();
    cyc_w(0, E_NONE, "nw_lw_memread"); tick();
    cyc_w(0, E_WB, "nw_lw_memwb");

    // illegal opcode: sticky trap until reset
    do_reset();
    set_ins(7'b1110011, 3'b000, 1'b0);
    cyc(1, E_FET, "ill_fetch"); tick();
    cyc(1, E_NONE, "ill_decode"); tick();
    for (int i = 0; i < 4; i++) begin
      cyc(1, E_ILL, $sformatf("ill_trap%0d", i)); tick();
    end
    reset_n = 1'b0;
    #1 chk("ill_cleared", 8'(sb_m), 8'(E_NONE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
